// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// data_ram : byte/half/word data memory with valid/ready handshake,
//            misalignment detection and configurable response wait states.
// Revision : 1.0
// ============================================================================
module data_ram #(
  parameter int SIZE = 14,
  parameter int WAIT = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic       WAIT_NONE = (WAIT == 0);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [3:0]      wait_cnt;
  logic [31:0]     mem [2**SIZE];

  logic            lat_we;
  logic            lat_uns;
  logic            lat_err;
  logic [1:0]      lat_size;
  logic [1:0]      lat_lo;
  logic [SIZE-1:0] lat_idx;

  logic [31:0]     rdata_q;
  logic            err_q;

  logic            accept;
  logic            req_err;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_rep;
  logic            enter_resp;

  logic            cur_we;
  logic            cur_uns;
  logic            cur_err;
  logic [1:0]      cur_size;
  logic [1:0]      cur_lo;
  logic [SIZE-1:0] cur_idx;
  logic [31:0]     word_rd;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_val;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^REQ_ADDR[31:SIZE+2];

  assign accept  = (state == S_IDLE) && REQ_VALID && !RST;
  assign req_err = (REQ_SIZE == 2'b11)
                || ((REQ_SIZE == 2'b01) && REQ_ADDR[0])
                || ((REQ_SIZE == 2'b10) && (REQ_ADDR[1:0] != 2'b00));

  always_comb begin
    byte_en   = 4'b1111;
    wdata_rep = REQ_WDATA;
    case (REQ_SIZE)
      2'b00: begin
        byte_en   = 4'b0001 << REQ_ADDR[1:0];
        wdata_rep = {4{REQ_WDATA[7:0]}};
      end
      2'b01: begin
        byte_en   = 4'b0011 << REQ_ADDR[1:0];
        wdata_rep = {2{REQ_WDATA[15:0]}};
      end
      default: ;
    endcase
  end

  // With no wait states the read happens on the accept edge, so use live inputs.
  always_comb begin
    if (state == S_IDLE) begin
      cur_we   = REQ_WE;
      cur_uns  = REQ_UNSIGNED;
      cur_err  = req_err;
      cur_size = REQ_SIZE;
      cur_lo   = REQ_ADDR[1:0];
      cur_idx  = REQ_ADDR[SIZE+1:2];
    end else begin
      cur_we   = lat_we;
      cur_uns  = lat_uns;
      cur_err  = lat_err;
      cur_size = lat_size;
      cur_lo   = lat_lo;
      cur_idx  = lat_idx;
    end
  end

  assign word_rd    = mem[cur_idx];
  assign enter_resp = !RST && ((accept && WAIT_NONE)
                            || ((state == S_WAIT) && (wait_cnt == 4'd0)));

  always_comb begin
    byte_sel = word_rd[{cur_lo, 3'b000} +: 8];
    half_sel = cur_lo[1] ? word_rd[31:16] : word_rd[15:0];
    case (cur_size)
      2'b00:   load_val = cur_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = cur_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = word_rd;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (REQ_VALID) state_nxt = WAIT_NONE ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  if (RSP_READY) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    REQ_READY = (state == S_IDLE);
    RSP_VALID = (state == S_RESP);
    RSP_RDATA = rdata_q;
    RSP_ERR   = err_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt <= WAIT_INIT;
        lat_we   <= REQ_WE;
        lat_uns  <= REQ_UNSIGNED;
        lat_err  <= req_err;
        lat_size <= REQ_SIZE;
        lat_lo   <= REQ_ADDR[1:0];
        lat_idx  <= REQ_ADDR[SIZE+1:2];
      end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (cur_we || cur_err) ? 32'd0 : load_val;
        err_q   <= cur_err;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (accept && REQ_WE && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[REQ_ADDR[SIZE+1:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
// tb_data_ram : exercises three data_ram instances (WAIT 0, WAIT 3, SIZE 4)
//               against a byte-addressed reference model.
// Revision    : 1.0
// ============================================================================
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [1:0]  req_size  [3];
  logic        req_uns   [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int errors = 0;
  int checks = 0;

  logic [7:0] mm [longint];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_ram #(.SIZE((g == 2) ? 4 : 14), .WAIT((g == 1) ? 3 : 0)) u_dut (
      .CLK(clk), .RST(rst),
      .REQ_VALID(req_valid[g]), .REQ_READY(req_ready[g]), .REQ_WE(req_we[g]),
      .REQ_SIZE(req_size[g]), .REQ_UNSIGNED(req_uns[g]), .REQ_ADDR(req_addr[g]),
      .REQ_WDATA(req_wdata[g]), .RSP_VALID(rsp_valid[g]), .RSP_READY(rsp_ready[g]),
      .RSP_RDATA(rsp_rdata[g]), .RSP_ERR(rsp_err[g])
    );
  end

  function automatic int wait_of(int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic longint bytes_of(int d);
    return (d == 2) ? 64 : 65536;
  endfunction

  function automatic longint key(int d, logic [31:0] a);
    return (longint'(d) << 32) | (longint'(a) % bytes_of(d));
  endfunction

  function automatic bit calc_err(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Little-endian byte memory; stores take the low 1/2/4 bytes of the data.
  function automatic void model_store(int d, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
    if (calc_err(sz, a)) return;
    for (int i = 0; i < (1 << sz); i++) mm[key(d, a + i)] = wd[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(int d, logic [1:0] sz, bit uns, logic [31:0] a);
    logic [31:0] v = 32'd0;
    int n;
    if (calc_err(sz, a)) return 32'd0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      longint k = key(d, a + i);
      if (mm.exists(k)) v = v | (32'(mm[k]) << (8*i));
    end
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // Drives one request and collects the observed response behaviour.
  task automatic xact(input int d, input bit we, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      output int lat, output logic [31:0] rd, output logic er,
                      output bit stable, output bit rr_low, output bit after_ok);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
    req_uns[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
    @(negedge clk);
    req_valid[d] = 1'b0; req_addr[d] = $urandom(); req_wdata[d] = $urandom();
    req_we[d] = 1'($urandom_range(0, 1));
    lat = 1; stable = 1'b1; rr_low = 1'b1; after_ok = 1'b0;
    rd = 32'hxxxx_xxxx; er = 1'bx;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      if (req_ready[d] !== 1'b0) rr_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (rsp_valid[d] !== 1'b1) begin
      lat = -1;
      return;
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      if (req_ready[d] !== 1'b0) rr_low = 1'b0;
      @(negedge clk);
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd || rsp_err[d] !== er) stable = 1'b0;
    end
    if (req_ready[d] !== 1'b0) rr_low = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    after_ok = (rsp_valid[d] === 1'b0) && (req_ready[d] === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_req_ready dut%0d got=%b exp=1", d, req_ready[d]); end
      checks++; if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid dut%0d got=%b exp=0", d, rsp_valid[d]); end
      checks++; if (rsp_rdata[d] !== 32'd0) begin errors++; $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rsp_rdata[d]); end
      checks++; if (rsp_err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got=%b exp=0", d, rsp_err[d]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_word;
    int lat; logic [31:0] rd; logic er; bit st, rl, ao;
    xact(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, lat, rd, er, st, rl, ao);
    model_store(0, 2'b10, 32'h100, 32'hDEAD_BEEF);
    checks++; if (lat != 1) begin errors++; $display("FAIL word_store_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL word_store_rsp got=%h/%b exp=0/0", rd, er); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (lat != 1) begin errors++; $display("FAIL word_load_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL word_load got=%h/%b exp=deadbeef/0", rd, er); end
    checks++; if (ao !== 1'b1) begin errors++; $display("FAIL word_after_handshake got=%b exp=1", ao); end
  endtask

  task automatic test_byte_half;
    int lat; logic [31:0] rd; logic er; bit st, rl, ao;
    xact(0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0, 0, lat, rd, er, st, rl, ao);
    xact(0, 1'b1, 2'b00, 1'b0, 32'h201, 32'hAAAA_AA80, 0, lat, rd, er, st, rl, ao);
    xact(0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h5555_F00D, 0, lat, rd, er, st, rl, ao);
    model_store(0, 2'b10, 32'h200, 32'h0);
    model_store(0, 2'b00, 32'h201, 32'hAAAA_AA80);
    model_store(0, 2'b01, 32'h202, 32'h5555_F00D);
    xact(0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'hF00D_8000 || er !== 1'b0) begin errors++; $display("FAIL bh_word got=%h/%b exp=f00d8000/0", rd, er); end
    xact(0, 1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL bh_lb got=%h exp=ffffff80", rd); end
    xact(0, 1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL bh_lbu got=%h exp=00000080", rd); end
    xact(0, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'hFFFF_F00D) begin errors++; $display("FAIL bh_lh got=%h exp=fffff00d", rd); end
  endtask

  task automatic test_misalign;
    int lat; logic [31:0] rd; logic er; bit st, rl, ao;
    xact(0, 1'b1, 2'b10, 1'b0, 32'h101, 32'h1234_5678, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL mis_sw got=%h/%b exp=0/1", rd, er); end
    xact(0, 1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL mis_lh got=%h/%b exp=0/1", rd, er); end
    xact(0, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL mis_size11 got=%h/%b exp=0/1", rd, er); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL mis_unchanged got=%h/%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_wait_backpressure;
    int lat; logic [31:0] rd; logic er; bit st, rl, ao;
    logic [31:0] v = $urandom();
    xact(1, 1'b1, 2'b10, 1'b0, 32'h40, v, 0, lat, rd, er, st, rl, ao);
    model_store(1, 2'b10, 32'h40, v);
    checks++; if (lat != 4) begin errors++; $display("FAIL wait_store_latency got=%0d exp=4", lat); end
    xact(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5, lat, rd, er, st, rl, ao);
    checks++; if (lat != 1 + wait_of(1)) begin errors++; $display("FAIL wait_load_latency got=%0d exp=4", lat); end
    checks++; if (rd !== model_load(1, 2'b10, 1'b0, 32'h40)) begin errors++; $display("FAIL wait_load_data got=%h exp=%h", rd, v); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL wait_stable got=%b exp=1", st); end
    checks++; if (rl !== 1'b1) begin errors++; $display("FAIL wait_req_ready_low got=%b exp=1", rl); end
    checks++; if (ao !== 1'b1) begin errors++; $display("FAIL wait_after_handshake got=%b exp=1", ao); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er; bit st, rl, ao;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
    req_addr[1] = 32'h180; req_wdata[1] = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid[1] = 1'b0;
    model_store(1, 2'b10, 32'h180, 32'hCAFE_F00D);
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL rstmid_in_wait got=%b exp=0", req_ready[1]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b/%b exp=1/0", req_ready[1], rsp_valid[1]); end
    // A request presented together with reset must be dropped.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
    req_addr[1] = 32'h180; req_wdata[1] = 32'h0BAD_BAD0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid[1] = 1'b0;
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL rst_override got=%b exp=1", req_ready[1]); end
    xact(1, 1'b0, 2'b10, 1'b0, 32'h180, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL rstmid_load got=%h/%b exp=cafef00d/0", rd, er); end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] rd; logic er; bit st, rl, ao;
    xact(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1122_3344, 0, lat, rd, er, st, rl, ao);
    model_store(2, 2'b10, 32'h40, 32'h1122_3344);
    xact(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 0, lat, rd, er, st, rl, ao);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL wrap got=%h exp=11223344", rd); end
  endtask

  task automatic test_random(input int d, input logic [31:0] base, input int n);
    int lat; logic [31:0] rd; logic er; bit st, rl, ao;
    logic [31:0] a, wd, exp_rd;
    logic [1:0] sz;
    bit we, uns, exp_er;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom();
      xact(d, 1'b1, 2'b10, 1'b0, base + 32'(4*i), wd, 0, lat, rd, er, st, rl, ao);
      model_store(d, 2'b10, base + 32'(4*i), wd);
    end
    for (int i = 0; i < n; i++) begin
      sz  = 2'($urandom_range(0, 3));
      a   = base + 32'($urandom_range(0, 63));
      if (d == 2) a = a + 32'(64 * $urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom();
      exp_er = calc_err(sz, a);
      exp_rd = we ? 32'd0 : model_load(d, sz, uns, a);
      xact(d, we, sz, uns, a, wd, $urandom_range(0, 2), lat, rd, er, st, rl, ao);
      if (we) model_store(d, sz, a, wd);
      checks++; if (lat != 1 + wait_of(d)) begin errors++; $display("FAIL rand_latency dut%0d op%0d got=%0d exp=%0d", d, i, lat, 1 + wait_of(d)); end
      checks++; if (rd !== exp_rd || er !== exp_er) begin errors++; $display("FAIL rand_rsp dut%0d op%0d we=%0d sz=%0d a=%h got=%h/%b exp=%h/%b", d, i, we, sz, a, rd, er, exp_rd, exp_er); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b10; req_uns[d] = 1'b0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
    end
    test_reset;
    test_word;
    test_byte_half;
    test_misalign;
    test_wait_backpressure;
    test_reset_mid;
    test_wrap;
    test_random(0, 32'h300, 40);
    test_random(1, 32'h500, 20);
    test_random(2, 32'h0, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
